// File: rtl/keccak_padder_pkg.sv
// Shared constants for the Keccak rate-block padder: rate geometry, pad bytes, FSM encodings.
package keccak_padder_pkg;

  localparam int unsigned RATE_BITS   = 1088;
  localparam logic [4:0]  RATE_WORDS  = 5'd17;
  localparam logic [7:0]  DOMAIN_BYTE = 8'h06;
  localparam logic [7:0]  FINAL_BIT   = 8'h80;

  localparam logic [1:0]  ST_FILL = 2'd0;
  localparam logic [1:0]  ST_PAD  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;

endpackage

// File: rtl/keccak_padder_pad_word.sv
// Builds the final message word: keeps the first byte_num bytes, appends the domain byte, zero-fills.
module pad_word
  import keccak_padder_pkg::*;
(
  input  logic [63:0] in,
  input  logic [2:0]  byte_num,
  output logic [63:0] out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < {29'b0, byte_num})
        out[63 - 8*i -: 8] = in[63 - 8*i -: 8];
      else if (i == {29'b0, byte_num})
        out[63 - 8*i -: 8] = DOMAIN_BYTE;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Collects 64-bit message words into 1088-bit rate blocks and applies Keccak multi-rate padding.
module keccak_padder
  import keccak_padder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [2:0]           byte_num,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack
);

  logic [1:0]  state;
  logic [4:0]  count;
  logic [63:0] padded;
  logic [63:0] word;
  logic        take_in;
  logic        take_pad;
  logic        last_slot;
  logic        final_blk;

  pad_word u_pad_word (
    .in       (in),
    .byte_num (byte_num),
    .out      (padded)
  );

  assign buffer_full = (count == RATE_WORDS);
  assign out_ready   = (count == RATE_WORDS);

  // final_blk marks a shift into the block that carries the end of the message,
  // so only that block gets the 0x80 terminator in its 17th slot.
  always_comb begin
    take_in   = (state == ST_FILL) && in_ready && !buffer_full;
    take_pad  = (state == ST_PAD) && !buffer_full;
    last_slot = (count == RATE_WORDS - 5'd1);
    final_blk = (take_in && is_last) || take_pad;
    word      = '0;
    if (take_in)
      word = is_last ? padded : in;
    if (final_blk && last_slot)
      word[7:0] = word[7:0] | FINAL_BIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      state <= ST_FILL;
      out   <= '0;
    end else if (out_ready && f_ack) begin
      count <= '0;
      if (state == ST_DONE)
        state <= ST_FILL;
    end else if (take_in || take_pad) begin
      out   <= {out[RATE_BITS-65:0], word};
      count <= count + 5'd1;
      if (final_blk)
        state <= last_slot ? ST_DONE : ST_PAD;
    end
  end

endmodule

// File: doc/keccak_padder.md
KECCAK_PADDER -- requirements
Module: keccak_padder

Interface
REQ-001 Parameters: none; rate fixed at 1088 bits (17 x 64-bit words).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset; clock is clk.
REQ-004 in  input  64  message word; byte 0 at in[63:56], byte 7 at in[7:0].
REQ-005 in_ready  input  1  in, is_last and byte_num are valid this cycle.
REQ-006 is_last  input  1  current word is the final word of the message.
REQ-007 byte_num  input  3  valid bytes in a final word, 0..7; ignored when is_last=0.
REQ-008 buffer_full  output  1  block buffer holds 17 words; no word is consumed while high.
REQ-009 out  output  1088  padded rate block; first word at out[1087:1024], last byte at out[7:0].
REQ-010 out_ready  output  1  out holds a complete block for the permutation core.
REQ-011 f_ack  input  1  permutation core has consumed out this cycle.

Function
REQ-012 A word is consumed when in_ready=1, buffer_full=0 and state=FILL; nothing else consumes input.
REQ-013 Each consumed or generated word shifts in: out <= {out[1023:0], word}; word count increments.
REQ-014 buffer_full = out_ready = (count == 17); asserted the cycle after the 17th word is shifted in.
REQ-015 f_ack while out_ready=1 clears count to 0 the next cycle; out contents then undefined-to-consumer.
REQ-016 f_ack while out_ready=0 is ignored.
REQ-017 Non-final word (is_last=0): shifted in unmodified; state stays FILL.
REQ-018 Final word: bytes 0..byte_num-1 from in, byte byte_num = 0x06, remaining bytes 0x00; state -> PAD.
REQ-019 byte_num=0 final word: word = 0x0600000000000000 (full 8-byte-aligned message sends an empty final word).
REQ-020 PAD: each cycle buffer not full, shift in a zero word; no input consumed.
REQ-021 Whichever word lands in slot 17 of the block that received the final word has bit 7 of its byte 7 set (0x80 OR'd into out[7:0]); 0x06 and 0x80 coinciding gives 0x86.
REQ-022 States: FILL -> PAD on final word; PAD -> DONE when final padded block reaches count 17; DONE -> FILL on f_ack.
REQ-023 Final word in slot 17: padding completes in that block, state goes directly to DONE.
REQ-024 Final word in slot 1..16: remaining slots zero-filled in PAD, 0x80 applied to slot 17.
REQ-025 Words arriving in DONE or PAD are not consumed; buffer_full=1 in DONE.
REQ-026 Zero padding cycles: one slot per clock, so a block from slot k completes in 17-k cycles.
REQ-027 No block ever contains bytes of two messages.

Reset
REQ-028 Reset: count=0, state=FILL, out=0, out_ready=0, buffer_full=0.
REQ-029 Reset mid-block or mid-PAD discards all partial data; no out_ready pulse follows.
REQ-030 Reset has priority over in_ready and f_ack in the same cycle.

Structure
REQ-031 Shared package holds RATE_BITS=1088, RATE_WORDS=17, DOMAIN_BYTE=0x06, FINAL_BIT=0x80, and state encodings.
REQ-032 One sub-module, pad_word: combinational (in, byte_num) -> padded 64-bit word per REQ-018/019.
REQ-033 Counter, FSM, shift register and 0x80 insertion live in keccak_padder.

Verification
REQ-034 Empty message: one word is_last=1 byte_num=0 -> 16 cycles later out_ready=1, out[1087:1080]=0x06, out[7:0]=0x80, rest 0.
REQ-035 16 words 0x1111..11 then final word 0xAABBCCDDEEFF0700 byte_num=7 -> one block, out[63:0]=0xAABBCCDDEEFF0786, state DONE.
REQ-036 17 full words then final word byte_num=0 -> block 1 exact data; block 2 after f_ack: 0x06 at top byte, 0x80 at out[7:0].
REQ-037 in_ready held high with f_ack delayed 5 cycles -> buffer_full high 5+ cycles, no words lost or duplicated.
REQ-038 Reset asserted after 9 words -> next cycle count=0, out=0, out_ready=0; new message processed cleanly.
